// File: rtl/mem_access_ctrl.sv
// Purpose : sequences one CPU load/store at a time into the 256x8 byte RAM (mv/moc handshake),
//           with bounds check, REQ timeout and sign/zero extension of load data.
// Latency : accept at edge k, moc sampled from k+1, done pulses the cycle after moc; bounds/misalign
//           errors pulse done right after the accept edge. Backpressure: ready=0 while busy; a req
//           seen while ready=0 is dropped, not queued. One request per 3 cycles at best.
//
// Ports:
//   clk, reset              clock and synchronous active-high reset
//   req/ready               request strobe / idle-and-accepting
//   we, size, ld_signed     store select, access size (byte/half/word/double), load sign-extend
//   addr, wdata             big-endian MSB-byte address, right-justified store data
//   rdata                   extended load result (held across stores and errors)
//   done, err, err_code     completion pulse, failure flag, 00 ok/01 bounds/10 misaligned/11 timeout
//   ram_*                   RAM side: address, din, dout, rw (1=read), mv strobe, type, moc
//
// Optional build macro: MISALIGN_TRAP_EN traps addresses not aligned to the access size
// (err_code 10) before any RAM access; without it misaligned accesses pass through.

module mem_access_ctrl #(
   parameter int ADDR_W      = 8,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   output logic              ready,
   input  logic              we,
   input  logic [1:0]        size,
   input  logic              ld_signed,
   input  logic [ADDR_W-1:0] addr,
   input  logic [63:0]       wdata,
   output logic [63:0]       rdata,
   output logic              done,
   output logic              err,
   output logic [1:0]        err_code,
   output logic [ADDR_W-1:0] ram_address,
   output logic [63:0]       ram_din,
   input  logic [63:0]       ram_dout,
   output logic              ram_rw,
   output logic              ram_mv,
   output logic [1:0]        ram_type,
   input  logic              ram_moc
);

   localparam int TW = $clog2(TIMEOUT_CYC);

   typedef enum logic [1:0] {IDLE, REQ, REL} state_t;

   state_t          state;
   logic [TW-1:0]   timer;
   logic            sgn_q;

   // span = bytes touched beyond addr; one extra carry bit flags running past the top of RAM
   logic [ADDR_W:0] span;
   logic [ADDR_W:0] end_addr;
   logic            bound_fail;

   always_comb begin
      span = '0;
      case (size)
         2'b00:   span = (ADDR_W+1)'(0);
         2'b01:   span = (ADDR_W+1)'(1);
         2'b10:   span = (ADDR_W+1)'(3);
         default: span = (ADDR_W+1)'(7);
      endcase
   end

   assign end_addr   = {1'b0, addr} + span;
   assign bound_fail = end_addr[ADDR_W];

`ifdef MISALIGN_TRAP_EN
   logic misalign;
   assign misalign = |(addr[2:0] & span[2:0]);
`endif

   function automatic logic [63:0] extend(input logic [63:0] d, input logic [1:0] sz,
                                          input logic sg);
      case (sz)
         2'b00:   extend = {{56{sg & d[7]}},  d[7:0]};
         2'b01:   extend = {{48{sg & d[15]}}, d[15:0]};
         2'b10:   extend = {{32{sg & d[31]}}, d[31:0]};
         default: extend = d;
      endcase
   endfunction

   // ram_type / ram_rw hold the accepted size and direction for the whole REQ phase,
   // so they double as the latched request fields.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         ready       <= 1'b1;
         ram_mv      <= 1'b0;
         ram_rw      <= 1'b1;
         done        <= 1'b0;
         err         <= 1'b0;
         err_code    <= 2'b00;
         rdata       <= '0;
         ram_address <= '0;
         ram_din     <= '0;
         ram_type    <= 2'b00;
         timer       <= '0;
         sgn_q       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  ready <= 1'b0;
                  if (bound_fail) begin
                     done     <= 1'b1;
                     err      <= 1'b1;
                     err_code <= 2'b01;
                     state    <= REL;
                  end
`ifdef MISALIGN_TRAP_EN
                  else if (misalign) begin
                     done     <= 1'b1;
                     err      <= 1'b1;
                     err_code <= 2'b10;
                     state    <= REL;
                  end
`endif
                  else begin
                     ram_address <= addr;
                     ram_type    <= size;
                     ram_din     <= wdata;
                     ram_rw      <= ~we;
                     ram_mv      <= 1'b1;
                     sgn_q       <= ld_signed;
                     timer       <= '0;
                     state       <= REQ;
                  end
               end
            end

            REQ: begin
               if (ram_moc) begin
                  ram_mv <= 1'b0;
                  if (ram_rw) begin
                     rdata <= extend(ram_dout, ram_type, sgn_q);
                  end
                  done     <= 1'b1;
                  err      <= 1'b0;
                  err_code <= 2'b00;
                  state    <= REL;
               end else if (timer == TW'(TIMEOUT_CYC-1)) begin
                  ram_mv   <= 1'b0;
                  done     <= 1'b1;
                  err      <= 1'b1;
                  err_code <= 2'b11;
                  state    <= REL;
               end else begin
                  timer <= timer + 1'b1;
               end
            end

            REL: begin
               // mv stays low here so the RAM always sees a fresh rising edge next time
               done  <= 1'b0;
               err   <= 1'b0;
               ready <= 1'b1;
               state <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

   logic        clk;
   logic        reset;
   logic        req;
   logic        ready;
   logic        we;
   logic [1:0]  size;
   logic        ld_signed;
   logic [7:0]  addr;
   logic [63:0] wdata;
   logic [63:0] rdata;
   logic        done;
   logic        err;
   logic [1:0]  err_code;
   logic [7:0]  ram_address;
   logic [63:0] ram_din;
   logic [63:0] ram_dout;
   logic        ram_rw;
   logic        ram_mv;
   logic [1:0]  ram_type;
   logic        ram_moc;

   int checks = 0;
   int errors = 0;

   mem_access_ctrl dut (
      .clk(clk), .reset(reset), .req(req), .ready(ready), .we(we), .size(size),
      .ld_signed(ld_signed), .addr(addr), .wdata(wdata), .rdata(rdata), .done(done),
      .err(err), .err_code(err_code), .ram_address(ram_address), .ram_din(ram_din),
      .ram_dout(ram_dout), .ram_rw(ram_rw), .ram_mv(ram_mv), .ram_type(ram_type),
      .ram_moc(ram_moc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- RAM environment: big-endian byte RAM, moc after mem_delay cycles of mv
   logic [7:0]      ram_mem [256];
   int              mem_delay = 1;     // 0 = never acknowledge
   int              mv_cnt = 0;
   int              rm_n;
   longint unsigned rm_v;

   always @(negedge clk) begin
      if (ram_mv) begin
         mv_cnt = mv_cnt + 1;
         if (!ram_moc && mem_delay != 0 && mv_cnt >= mem_delay) begin
            rm_n = 1 << ram_type;
            if (ram_rw) begin
               rm_v = 0;
               for (int i = 0; i < rm_n; i++) rm_v = (rm_v << 8) | 64'(ram_mem[8'(ram_address + i)]);
               ram_dout = rm_v;
            end else begin
               for (int i = 0; i < rm_n; i++)
                  ram_mem[8'(ram_address + i)] = 8'(ram_din >> (8 * (rm_n - 1 - i)));
            end
            ram_moc = 1'b1;
         end
      end else begin
         mv_cnt   = 0;
         ram_moc  = 1'b0;
         ram_dout = {$urandom, $urandom};
      end
   end

   // ---------------- reference model: byte array + last load result
   logic [7:0]  ref_mem [256];
   logic [63:0] ref_rdata = '0;

   task automatic model_req(input logic w, input logic [1:0] sz, input logic sg,
                            input logic [7:0] a, input logic [63:0] wd, input int dly,
                            output logic [1:0] code, output logic [63:0] rd, output int lat);
      int n;
      longint unsigned v;
      n = 1 << sz;
      if (int'(a) + n > 256) begin
         code = 2'b01; lat = 0;
      end
`ifdef MISALIGN_TRAP_EN
      else if (int'(a) % n != 0) begin
         code = 2'b10; lat = 0;
      end
`endif
      else if (dly == 0 || dly > 16) begin
         code = 2'b11; lat = 16;
      end else begin
         code = 2'b00; lat = dly;
         if (w) begin
            for (int i = 0; i < n; i++) ref_mem[8'(int'(a) + i)] = 8'(wd >> (8 * (n - 1 - i)));
         end else begin
            v = 0;
            for (int i = 0; i < n; i++) v = v * 256 + 64'(ref_mem[8'(int'(a) + i)]);
            if (sg && n < 8 && v >= (64'd1 << (8 * n - 1))) v = v - (64'd1 << (8 * n));
            ref_rdata = v;
         end
      end
      rd = ref_rdata;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one request from an idle sample point and follow it to completion.
   task automatic run_req(input string tag, input logic w, input logic [1:0] sz, input logic sg,
                          input logic [7:0] a, input logic [63:0] wd, input int dly,
                          input logic [1:0] ecode, input logic [63:0] erd, input int elat);
      int  c;
      int  mvc;
      bit  access;
      access = (ecode == 2'b00 || ecode == 2'b11);
      chk({tag, " ready_idle"}, ready, 1);
      mem_delay = dly;
      req = 1'b1; we = w; size = sz; ld_signed = sg; addr = a; wdata = wd;
      @(posedge clk); #1;
      req = 1'b0;
      c = 0; mvc = 0;
      if (access) begin
         chk({tag, " mv_first"}, ram_mv, 1);
         chk({tag, " ram_address"}, ram_address, a);
         chk({tag, " ram_type"}, ram_type, sz);
         chk({tag, " ram_rw"}, ram_rw, !w);
         if (w) chk({tag, " ram_din"}, ram_din, wd);
      end else begin
         chk({tag, " no_mv"}, ram_mv, 0);
      end
      while (!done && c < 40) begin
         if (ram_mv) mvc++;
         @(posedge clk); #1;
         c++;
      end
      chk({tag, " done"}, done, 1);
      chk({tag, " latency"}, c, elat);
      chk({tag, " mv_cycles"}, mvc, access ? elat : 0);
      chk({tag, " err"}, err, ecode != 2'b00);
      chk({tag, " err_code"}, err_code, ecode);
      chk({tag, " rdata"}, rdata, erd);
      chk({tag, " ready_busy"}, ready, 0);
      @(posedge clk); #1;
      chk({tag, " done_drop"}, done, 0);
      chk({tag, " err_drop"}, err, 0);
      chk({tag, " ready_back"}, ready, 1);
      chk({tag, " err_code_hold"}, err_code, ecode);
      chk({tag, " mv_low"}, ram_mv, 0);
   endtask

   typedef struct {
      logic        w;
      logic [1:0]  sz;
      logic        sg;
      logic [7:0]  a;
      logic [63:0] wd;
      int          dly;
      logic [1:0]  code;
      logic [63:0] rd;
      int          lat;
   } vec_t;

   function automatic vec_t mk(logic w, logic [1:0] sz, logic sg, logic [7:0] a,
                               logic [63:0] wd, int dly, logic [1:0] code,
                               logic [63:0] rd, int lat);
      vec_t v;
      v.w = w; v.sz = sz; v.sg = sg; v.a = a; v.wd = wd; v.dly = dly;
      v.code = code; v.rd = rd; v.lat = lat;
      return v;
   endfunction

   vec_t tbl [19];

   initial begin
      logic [1:0]  mc;
      logic [63:0] mrd;
      int          mlat;
      int          dcount;
      logic        rw;
      logic [1:0]  rsz;
      logic        rsg;
      logic [7:0]  ra;
      logic [7:0]  rmask;
      logic [63:0] rwd;
      int          rdly;
      int          r;

      for (int i = 0; i < 256; i++) ram_mem[i] = 8'(i);
      ram_mem[8'h10] = 8'h80; ram_mem[8'h11] = 8'h00; ram_mem[8'h12] = 8'h00; ram_mem[8'h13] = 8'h01;
      for (int i = 0; i < 256; i++) ref_mem[i] = ram_mem[i];

      // store/load/err expectations worked out by hand; rdata carries over between rows
      tbl[0]  = mk(0, 2'd2, 1, 8'h10, 64'h0, 1, 2'b00, 64'hFFFF_FFFF_8000_0001, 1);
      tbl[1]  = mk(1, 2'd1, 0, 8'h20, 64'hBEEF, 1, 2'b00, 64'hFFFF_FFFF_8000_0001, 1);
      tbl[2]  = mk(0, 2'd1, 0, 8'h20, 64'h0, 2, 2'b00, 64'h0000_0000_0000_BEEF, 2);
      tbl[3]  = mk(0, 2'd3, 0, 8'hFC, 64'h0, 1, 2'b01, 64'h0000_0000_0000_BEEF, 0);
      tbl[4]  = mk(0, 2'd2, 1, 8'h10, 64'h0, 0, 2'b11, 64'h0000_0000_0000_BEEF, 16);
`ifdef MISALIGN_TRAP_EN
      tbl[5]  = mk(0, 2'd2, 1, 8'h02, 64'h0, 1, 2'b10, 64'h0000_0000_0000_BEEF, 0);
`else
      tbl[5]  = mk(0, 2'd2, 1, 8'h02, 64'h0, 1, 2'b00, 64'h0000_0000_0203_0405, 1);
`endif
      tbl[6]  = mk(0, 2'd0, 1, 8'hFF, 64'h0, 1, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 1);
      tbl[7]  = mk(0, 2'd1, 0, 8'hFF, 64'h0, 1, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 0);
      tbl[8]  = mk(0, 2'd0, 0, 8'h10, 64'h0, 1, 2'b00, 64'h0000_0000_0000_0080, 1);
      tbl[9]  = mk(0, 2'd0, 1, 8'h10, 64'h0, 1, 2'b00, 64'hFFFF_FFFF_FFFF_FF80, 1);
      tbl[10] = mk(0, 2'd3, 0, 8'hF8, 64'h0, 3, 2'b00, 64'hF8F9_FAFB_FCFD_FEFF, 3);
      tbl[11] = mk(0, 2'd0, 1, 8'h11, 64'h0, 16, 2'b00, 64'h0, 16);
      tbl[12] = mk(0, 2'd0, 1, 8'h11, 64'h0, 17, 2'b11, 64'h0, 16);
      tbl[13] = mk(1, 2'd2, 0, 8'h40, 64'h1234_5678, 2, 2'b00, 64'h0, 2);
      tbl[14] = mk(1, 2'd0, 0, 8'h41, 64'hDEAD_BEEF_0000_00AB, 1, 2'b00, 64'h0, 1);
      tbl[15] = mk(0, 2'd2, 1, 8'h40, 64'h0, 1, 2'b00, 64'h0000_0000_12AB_5678, 1);
      tbl[16] = mk(0, 2'd1, 1, 8'h20, 64'h0, 1, 2'b00, 64'hFFFF_FFFF_FFFF_BEEF, 1);
      tbl[17] = mk(0, 2'd2, 0, 8'hFC, 64'h0, 1, 2'b00, 64'h0000_0000_FCFD_FEFF, 1);
      tbl[18] = mk(0, 2'd2, 0, 8'hFD, 64'h0, 1, 2'b01, 64'h0000_0000_FCFD_FEFF, 0);

      reset = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; ld_signed = 1'b0;
      addr = 8'h00; wdata = 64'h0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst ready", ready, 1);
      chk("rst mv", ram_mv, 0);
      chk("rst rw", ram_rw, 1);
      chk("rst done", done, 0);
      chk("rst err", err, 0);
      chk("rst err_code", err_code, 0);
      chk("rst rdata", rdata, 0);
      chk("rst ram_address", ram_address, 0);
      chk("rst ram_din", ram_din, 0);
      chk("rst ram_type", ram_type, 0);
      reset = 1'b0;
      @(posedge clk); #1;

      // ---- directed table
      for (int i = 0; i < 19; i++) begin
         run_req($sformatf("vec%0d", i), tbl[i].w, tbl[i].sz, tbl[i].sg, tbl[i].a, tbl[i].wd,
                 tbl[i].dly, tbl[i].code, tbl[i].rd, tbl[i].lat);
         model_req(tbl[i].w, tbl[i].sz, tbl[i].sg, tbl[i].a, tbl[i].wd, tbl[i].dly, mc, mrd, mlat);
      end

      // ---- reset while in REQ: mv drops, no done, req under reset not taken
      mem_delay = 0;
      req = 1'b1; we = 1'b0; size = 2'd2; ld_signed = 1'b0; addr = 8'h10;
      @(posedge clk); #1;
      req = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rstreq mv_before", ram_mv, 1);
      reset = 1'b1; req = 1'b1;
      @(posedge clk); #1;
      chk("rstreq mv", ram_mv, 0);
      chk("rstreq ready", ready, 1);
      chk("rstreq done", done, 0);
      chk("rstreq err_code", err_code, 0);
      @(posedge clk); #1;
      chk("rstreq req_ignored_ready", ready, 1);
      chk("rstreq req_ignored_mv", ram_mv, 0);
      reset = 1'b0; req = 1'b0;
      dcount = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (done) dcount++;
      end
      chk("rstreq no_done", dcount, 0);
      chk("rstreq rdata", rdata, 0);
      ref_rdata = '0;

      // ---- req pulsed during REL is dropped
      mem_delay = 1;
      req = 1'b1; we = 1'b0; size = 2'd0; ld_signed = 1'b0; addr = 8'h10;
      @(posedge clk); #1;
      req = 1'b0;
      @(posedge clk); #1;
      chk("rel done", done, 1);
      chk("rel rdata", rdata, 64'h80);
      model_req(0, 2'd0, 0, 8'h10, 64'h0, 1, mc, mrd, mlat);
      req = 1'b1; addr = 8'h20;
      @(posedge clk); #1;
      chk("rel done_drop", done, 0);
      chk("rel ready", ready, 1);
      chk("rel mv", ram_mv, 0);
      req = 1'b0;
      @(posedge clk); #1;
      chk("rel ignored_ready", ready, 1);
      chk("rel ignored_mv", ram_mv, 0);

      // ---- randomized requests against the reference model
      for (int k = 0; k < 60; k++) begin
         rw  = 1'($urandom_range(0, 1));
         rsz = 2'($urandom_range(0, 3));
         rsg = 1'($urandom_range(0, 1));
         rwd = {$urandom, $urandom};
         if ($urandom_range(0, 3) == 0) ra = 8'(255 - $urandom_range(0, 8));
         else                           ra = 8'($urandom);
         if ($urandom_range(0, 1) == 0) begin
            rmask = 8'((1 << rsz) - 1);
            ra = ra & ~rmask;
         end
         r = $urandom_range(0, 9);
         if (r == 0)      rdly = 0;
         else if (r == 1) rdly = $urandom_range(16, 17);
         else             rdly = $urandom_range(1, 5);
         model_req(rw, rsz, rsg, ra, rwd, rdly, mc, mrd, mlat);
         run_req($sformatf("rnd%0d", k), rw, rsz, rsg, ra, rwd, rdly, mc, mrd, mlat);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
